// File: rtl/easyaxi_ar_arb_if.sv
// AR-channel bundle for the round-robin arbiter: MST_NUM upstream request
// ports on one side, a single downstream AR port plus grant/busy on the other.
interface easyaxi_ar_arb_if #(
    parameter int MST_NUM = 4,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int GNT_W   = $clog2(MST_NUM)
) ();

    logic                      enable;
    logic [MST_NUM-1:0]        s_arvalid;
    logic [MST_NUM-1:0]        s_arready;
    logic [MST_NUM*ID_W-1:0]   s_arid;
    logic [MST_NUM*ADDR_W-1:0] s_araddr;
    logic                      m_arvalid;
    logic                      m_arready;
    logic [ID_W-1:0]           m_arid;
    logic [ADDR_W-1:0]         m_araddr;
    logic [GNT_W-1:0]          m_grant;
    logic                      busy;

    // The arbiter itself
    modport slave (
        input  enable, s_arvalid, s_arid, s_araddr, m_arready,
        output s_arready, m_arvalid, m_arid, m_araddr, m_grant, busy
    );

    // Whatever surrounds the arbiter: upstream masters plus downstream slave
    modport master (
        output enable, s_arvalid, s_arid, s_araddr, m_arready,
        input  s_arready, m_arvalid, m_arid, m_araddr, m_grant, busy
    );

endinterface

// File: rtl/easyaxi_ar_arb.sv
// Round-robin AR-channel arbiter: MST_NUM masters share one downstream AR port
// through a single registered output stage that supports 1 request per cycle.
module easyaxi_ar_arb #(
    parameter int MST_NUM = 4,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int GNT_W   = $clog2(MST_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    easyaxi_ar_arb_if.slave    bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [GNT_W-1:0]    ptr_q, ptr_d;
    logic [GNT_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [GNT_W-1:0]    winner;
    logic                winner_found;
    logic                can_accept;
    logic                accept;

    // Search upward from ptr_q with wrap; MST_NUM need not be a power of two,
    // so the wrap is an explicit subtract rather than a truncation.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner       = '0;
        winner_found = 1'b0;
        idx          = 0;
        for (int k = 0; k < MST_NUM; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= MST_NUM) begin
                idx = idx - MST_NUM;
            end
            if (!winner_found && bus.s_arvalid[idx]) begin
                winner_found = 1'b1;
                winner       = GNT_W'(idx);
            end
        end
    end

    // Gating with rst_n keeps every ready low while reset is asserted.
    assign can_accept = rst_n & bus.enable & ((state_q == EMPTY) | bus.m_arready);
    assign accept     = can_accept & winner_found;

    always_comb begin
        bus.s_arready = '0;
        if (accept) begin
            bus.s_arready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        addr_d  = addr_q;
        if (accept) begin
            state_d = FULL;
            grant_d = winner;
            id_d    = bus.s_arid[int'(winner)*ID_W +: ID_W];
            addr_d  = bus.s_araddr[int'(winner)*ADDR_W +: ADDR_W];
            ptr_d   = (winner == GNT_W'(MST_NUM - 1)) ? '0 : winner + 1'b1;
        end else if ((state_q == FULL) && bus.m_arready) begin
            // Payload registers keep their last values once drained.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.m_arvalid = (state_q == FULL);
    assign bus.busy      = (state_q == FULL);
    assign bus.m_arid    = id_q;
    assign bus.m_araddr  = addr_q;
    assign bus.m_grant   = grant_q;

endmodule

// File: tb/tb_easyaxi_ar_arb.sv
// Self-checking bench: a 4-master instance driven against a reference model and
// output scoreboard, plus a 3-master instance for the non-power-of-two wrap case.
module tb_easyaxi_ar_arb;

    logic clk;
    logic rst_n;

    easyaxi_ar_arb_if #(.MST_NUM(4), .ID_W(4), .ADDR_W(32)) a ();
    easyaxi_ar_arb_if #(.MST_NUM(3), .ID_W(4), .ADDR_W(32)) b ();

    easyaxi_ar_arb #(.MST_NUM(4), .ID_W(4), .ADDR_W(32)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    easyaxi_ar_arb #(.MST_NUM(3), .ID_W(4), .ADDR_W(32)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  g;
        logic [3:0]  id;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   mptr;
    bit   mfull;
    int   n_cmp;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] id, input logic [31:0] addr);
        a.s_arid[i*4 +: 4]    = id;
        a.s_araddr[i*32 +: 32] = addr;
    endtask

    // One clock of DUT A: model ready/valid at the negedge, compare, update model.
    task automatic cycle_a();
        int         w;
        bit         can;
        logic [3:0] exp_rdy;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (mptr + k) % 4;
            if (w < 0 && a.s_arvalid[idx]) w = idx;
        end
        can     = a.enable && (!mfull || a.m_arready);
        exp_rdy = (can && w >= 0) ? 4'(1 << w) : 4'b0;
        chk("a_s_arready", 32'(a.s_arready), 32'(exp_rdy));
        chk("a_m_arvalid", 32'(a.m_arvalid), 32'(mfull));
        chk("a_busy", 32'(a.busy), 32'(mfull));
        if (mfull) begin
            chk("a_sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("a_m_grant", 32'(a.m_grant), 32'(sb[0].g));
                chk("a_m_arid", 32'(a.m_arid), 32'(sb[0].id));
                chk("a_m_araddr", a.m_araddr, sb[0].addr);
                if (a.m_arready) void'(sb.pop_front());
            end
        end
        if (can && w >= 0) begin
            sb.push_back('{g: 2'(w), id: a.s_arid[w*4 +: 4], addr: a.s_araddr[w*32 +: 32]});
            mptr = (w == 3) ? 0 : w + 1;
        end
        mfull = (can && w >= 0) ? 1'b1 : ((mfull && a.m_arready) ? 1'b0 : mfull);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mfull = 1'b0;
        mptr  = 0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n       = 1'b0;
        a.enable    = 1'b1;
        a.s_arvalid = 4'b1111;
        a.s_arid    = '0;
        a.s_araddr  = '0;
        a.m_arready = 1'b0;
        b.enable    = 1'b1;
        b.s_arvalid = '0;
        b.s_arid    = '0;
        b.s_araddr  = '0;
        b.m_arready = 1'b0;

        // Reset state, with requests pending to show ready is held low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_arvalid", 32'(a.m_arvalid), 32'd0);
        chk("rst_busy", 32'(a.busy), 32'd0);
        chk("rst_m_arid", 32'(a.m_arid), 32'd0);
        chk("rst_m_araddr", a.m_araddr, 32'd0);
        chk("rst_m_grant", 32'(a.m_grant), 32'd0);
        chk("rst_s_arready", 32'(a.s_arready), 32'd0);
        a.s_arvalid = 4'b0000;
        rst_n = 1'b1;

        // Single requester (master 2) with a 3-cycle downstream stall.
        set_req(2, 4'h5, 32'h0000_2000);
        a.s_arvalid = 4'b0100;
        cycle_a();
        a.s_arvalid = 4'b0000;
        repeat (3) cycle_a();
        a.m_arready = 1'b1;
        cycle_a();
        cycle_a();

        // Reset while FULL holding address 0x1000: must clear with no clock edge.
        a.m_arready = 1'b0;
        set_req(0, 4'h3, 32'h0000_1000);
        a.s_arvalid = 4'b0001;
        cycle_a();
        chk("full_before_rst_addr", a.m_araddr, 32'h0000_1000);
        a.s_arvalid = 4'b1111;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_m_arvalid", 32'(a.m_arvalid), 32'd0);
        chk("midrst_m_araddr", a.m_araddr, 32'd0);
        chk("midrst_m_arid", 32'(a.m_arid), 32'd0);
        chk("midrst_m_grant", 32'(a.m_grant), 32'd0);
        chk("midrst_busy", 32'(a.busy), 32'd0);
        chk("midrst_s_arready", 32'(a.s_arready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four requesting with m_arready tied high: grants 0,1,2,3,0,1.
        for (int i = 0; i < 4; i++) set_req(i, 4'(8 + i), 32'h100 * (i + 1));
        a.s_arvalid = 4'b1111;
        a.m_arready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle_a();
            chk("rr_grant_order", 32'(a.m_grant), 32'(i % 4));
        end
        a.s_arvalid = 4'b0000;
        cycle_a();
        cycle_a();

        // Pointer wrap: grant master 3, then only 0 and 3 request -> 0 then 3.
        a.s_arvalid = 4'b1000;
        cycle_a();
        chk("wrap_first", 32'(a.m_grant), 32'd3);
        a.s_arvalid = 4'b1001;
        cycle_a();
        chk("wrap_second", 32'(a.m_grant), 32'd0);
        cycle_a();
        chk("wrap_third", 32'(a.m_grant), 32'd3);
        a.s_arvalid = 4'b0000;
        cycle_a();
        cycle_a();

        // enable low while FULL: held request drains, master 1 waits for enable.
        a.m_arready = 1'b0;
        set_req(2, 4'hA, 32'hDEAD_0000);
        a.s_arvalid = 4'b0100;
        cycle_a();
        set_req(1, 4'h7, 32'h0000_7700);
        a.s_arvalid = 4'b0010;
        a.enable    = 1'b0;
        cycle_a();
        a.m_arready = 1'b1;
        cycle_a();
        cycle_a();
        chk("en_low_drained", 32'(a.m_arvalid), 32'd0);
        a.enable = 1'b1;
        cycle_a();
        chk("en_high_accept_grant", 32'(a.m_grant), 32'd1);
        a.s_arvalid = 4'b0000;
        cycle_a();
        cycle_a();
        chk("a_sb_drained", 32'(sb.size()), 32'd0);

        // MST_NUM=3: reload on the same edge as the downstream handshake.
        b.s_arvalid         = 3'b100;
        b.s_arid[8 +: 4]    = 4'h2;
        b.s_araddr[64 +: 32] = 32'h0000_0200;
        b.m_arready         = 1'b0;
        @(negedge clk);
        chk("b_rdy_m2", 32'(b.s_arready), 32'b100);
        @(posedge clk);
        #1;
        b.s_arvalid         = 3'b001;
        b.s_arid[0 +: 4]    = 4'h1;
        b.s_araddr[0 +: 32] = 32'h0000_0040;
        b.m_arready         = 1'b1;
        @(negedge clk);
        chk("b_full_valid", 32'(b.m_arvalid), 32'd1);
        chk("b_full_grant", 32'(b.m_grant), 32'd2);
        chk("b_full_addr", b.m_araddr, 32'h0000_0200);
        chk("b_rdy_m0", 32'(b.s_arready), 32'b001);
        @(posedge clk);
        #1;
        chk("b_reload_valid", 32'(b.m_arvalid), 32'd1);
        chk("b_reload_grant", 32'(b.m_grant), 32'd0);
        chk("b_reload_addr", b.m_araddr, 32'h0000_0040);
        chk("b_reload_id", 32'(b.m_arid), 32'h1);

        // ptr is now 1: all three requesting gives 1, 2, then wraps to 0.
        b.s_arvalid = 3'b111;
        @(negedge clk);
        chk("b_ptr1_rdy", 32'(b.s_arready), 32'b010);
        @(posedge clk);
        #1;
        chk("b_ptr1_grant", 32'(b.m_grant), 32'd1);
        @(negedge clk);
        chk("b_ptr2_rdy", 32'(b.s_arready), 32'b100);
        @(posedge clk);
        #1;
        chk("b_ptr2_grant", 32'(b.m_grant), 32'd2);
        @(negedge clk);
        chk("b_wrap_rdy", 32'(b.s_arready), 32'b001);
        @(posedge clk);
        #1;
        chk("b_wrap_grant", 32'(b.m_grant), 32'd0);
        b.s_arvalid = 3'b000;
        @(posedge clk);
        #1;
        chk("b_empty", 32'(b.m_arvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/easyaxi_ar_arb.md
Name: easyaxi_ar_arb

Overview:
- Round-robin arbiter that shares one AXI read-address (AR) channel between MST_NUM requesting masters and one downstream slave port.
- Sits between several AR-channel masters and a single AR-channel slave in the top-level link wiring, in place of a direct master-to-slave connection.
- Accepts one request at a time into a registered output stage and holds it until the slave accepts it.
- Records which master won so that a later read-data router can return responses.

Parameters:
- MST_NUM, 4, number of requesting masters; legal range 2..8, need not be a power of two.
- ID_W, 4, AR ID width; matches the AXI ID width define.
- ADDR_W, 32, AR address width; matches the AXI address width define.
- GNT_W, $clog2(MST_NUM), width of the grant index.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  arbitration enable; when low, no new request is accepted.
- s_arvalid  input  MST_NUM  per-master AR valid; bit i belongs to master i.
- s_arready  output  MST_NUM  per-master AR ready.
- s_arid  input  MST_NUM*ID_W  packed IDs; master i occupies bits [i*ID_W +: ID_W].
- s_araddr  input  MST_NUM*ADDR_W  packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_arvalid  output  1  downstream AR valid (registered).
- m_arready  input  1  downstream AR ready.
- m_arid  output  ID_W  registered ID of the granted request.
- m_araddr  output  ADDR_W  registered address of the granted request.
- m_grant  output  GNT_W  index of the master that owns the request on m_*.
- busy  output  1  high whenever m_arvalid is high.

Behaviour:
- Reset (rst_n low, asynchronous): m_arvalid=0, m_arid=0, m_araddr=0, m_grant=0, busy=0, round-robin pointer ptr=0.
  - s_arready is combinational and is 0 during reset.
  - Reset mid-transfer drops the held request silently.
- Output stage states:
  - EMPTY: m_arvalid=0.
  - FULL: m_arvalid=1.
- Define can_accept = enable & (EMPTY | m_arready).
- Arbitration (combinational):
  - Search s_arvalid starting at index ptr, upward with wrap from MST_NUM-1 to 0.
  - The first set bit is the winner w.
  - If no bit is set, there is no winner.
- s_arready[w] = can_accept & winner_exists. All other s_arready bits are 0.
  - At most one s_arready bit is ever high.
  - s_arready never depends on s_arvalid of other masters beyond the arbitration search.
- On an accept edge (s_arvalid[w] & s_arready[w]):
  - m_arid  <= s_arid slice w.
  - m_araddr <= s_araddr slice w.
  - m_grant <= w.
  - m_arvalid <= 1, go to FULL.
  - ptr <= (w==MST_NUM-1) ? 0 : w+1.
- FULL with m_arready=1 and no new accept: m_arvalid <= 0, go to EMPTY. The data registers keep their values.
- FULL with m_arready=1 and a new accept in the same cycle: the registers load the new request and m_arvalid stays 1.
  - This gives back-to-back throughput of 1 request per cycle.
- FULL with m_arready=0: m_arvalid, m_arid, m_araddr and m_grant are held stable (AXI rule). No accept occurs.
- Latency: accepted at edge N, m_arvalid is visible after edge N. Minimum 1 cycle from upstream handshake to downstream valid.
- enable low:
  - No accept occurs.
  - A request already in FULL still completes on m_arready and then goes to EMPTY.
  - ptr is unchanged.
- An upstream master must hold valid and payload until its ready. The arbiter does not check this.
- Fairness: a continuously requesting master waits at most MST_NUM-1 grants.
- busy = m_arvalid.

Test Plan:
- Reset mid-FULL:
  - Stimulus: assert rst_n=0 while m_arvalid=1, m_araddr=0x1000.
  - Response: m_arvalid=0, m_araddr=0, ptr=0 immediately, with no clock edge required.
- Single requester with a stalling slave:
  - Stimulus: master 2 sends id=0x5, addr=0x0000_2000; m_arready low for 3 cycles.
  - Response: s_arready[2] is high for 1 cycle, then m_arvalid=1 with id/addr/m_grant=2 stable for 3 cycles; goes EMPTY after the handshake.
- All four requesting with m_arready tied 1:
  - Stimulus: masters 0, 1, 2, 3 request continuously.
  - Response: grant order is 0,1,2,3,0,1; one accept per cycle; m_arvalid stays continuously high.
- Pointer wrap:
  - Stimulus: grant master 3, then only masters 0 and 3 request.
  - Response: next grant is 0, then 3.
- enable low while FULL:
  - Stimulus: enable=0 with m_arvalid=1 and master 1 requesting; then m_arready=1.
  - Response: the held request completes, no s_arready is asserted, the stage goes EMPTY. After enable returns to 1, master 1 is accepted.
- Simultaneous downstream handshake and new request with MST_NUM=3:
  - Stimulus: FULL holding m_grant=2; m_arready=1 in the same cycle master 0 requests addr=0x40.
  - Response: registers reload on that edge to m_grant=0, m_araddr=0x40; m_arvalid stays 1; ptr becomes 1.
